// File: rtl/res_stream_out.sv
// res_stream_out: streams NUM_WORDS results from the RES RAM as one AXI4-Stream packet.
// A 2-entry skid buffer absorbs back-pressure. The RAM word counts as buffered in the
// cycle it arrives, so the first beat follows the first read by one cycle.
// Optional feature: define RES_SIGN_EXTEND_EN to sign-extend results into the upper
// TDATA bits. When it is undefined, those bits are zero-filled.
module res_stream_out #(
  parameter int unsigned width          = 8,
  parameter int unsigned RES_depth_bits = 6,
  parameter int unsigned NUM_WORDS      = 64,
  parameter int unsigned AXIS_width     = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [AXIS_width-1:0]     M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST
);

  localparam int unsigned CntW = $clog2(NUM_WORDS + 1);
  localparam logic [CntW-1:0] NumWordsC = CntW'(NUM_WORDS);
  localparam logic [CntW-1:0] LastIdxC = CntW'(NUM_WORDS - 1);
  localparam logic [RES_depth_bits-1:0] LastAddrC = RES_depth_bits'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFinish} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0]           sent_cnt_q, sent_cnt_d;
  logic [RES_depth_bits-1:0] addr_q, addr_d;
  logic [1:0]                occ_q, occ_d;
  logic                      inflight_q, inflight_d;
  logic [width-1:0]          buf0_q, buf0_d;
  logic [width-1:0]          buf1_q, buf1_d;

  logic             start_acc;
  logic             push;
  logic             pop;
  logic             out_valid;
  logic [width-1:0] head;
  logic             fill;

  // The word on the RAM output is presented directly when the buffer is empty.
  assign push      = inflight_q;
  assign out_valid = (occ_q != 2'd0) | inflight_q;
  assign head      = (occ_q != 2'd0) ? buf0_q : RES_read_data_out;
  assign pop       = out_valid & M_AXIS_TREADY;

  // FSM next-state and status outputs
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StStream;
          start_acc = 1'b1;
        end
      end
      StStream: begin
        busy = 1'b1;
        if (pop && M_AXIS_TLAST) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read issue: registered occupancy plus the in-flight read never exceeds the two slots
  always_comb begin
    RES_read_en      = (state_q == StStream) && (rd_cnt_q < NumWordsC) &&
                       ((occ_q + {1'b0, inflight_q}) < 2'd2);
    RES_read_address = addr_q;
    inflight_d       = RES_read_en;
    rd_cnt_d         = rd_cnt_q;
    addr_d           = addr_q;
    if (start_acc) begin
      rd_cnt_d = '0;
      addr_d   = '0;
    end else if (RES_read_en) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      // Hold on the final address rather than wrapping
      if (addr_q != LastAddrC) begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Skid buffer update: buf0 is the head, buf1 queues behind it
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = RES_read_data_out;
        end else begin
          buf1_d = RES_read_data_out;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; when empty the arriving word leaves directly
        if (occ_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = RES_read_data_out;
        end else if (occ_q == 2'd1) begin
          buf0_d = RES_read_data_out;
        end
      end
      default: ;
    endcase
  end

  // Beat counter drives TLAST
  always_comb begin
    sent_cnt_d = sent_cnt_q;
    if (start_acc) begin
      sent_cnt_d = '0;
    end else if (pop) begin
      sent_cnt_d = sent_cnt_q + 1'b1;
    end
  end

`ifdef RES_SIGN_EXTEND_EN
  assign fill = head[width-1];
`else
  assign fill = 1'b0;
`endif

  // Stream outputs, forced to zero when no beat is presented
  always_comb begin
    M_AXIS_TVALID = out_valid;
    M_AXIS_TLAST  = out_valid && (sent_cnt_q == LastIdxC);
    M_AXIS_TDATA  = '0;
    if (out_valid) begin
      M_AXIS_TDATA              = {AXIS_width{fill}};
      M_AXIS_TDATA[width-1:0]   = head;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      rd_cnt_q   <= '0;
      sent_cnt_q <= '0;
      addr_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      addr_q     <= addr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule
